// File: rtl/ft232h_bus_arbiter.sv
// Shares the FT232H async-FIFO data bus between the RX and TX byte engines:
// round-robin grant, bounded bursts, and idle turnaround before every owner change.
module ft232h_bus_arbiter #(
  parameter int unsigned TURN_CLK  = 2,
  parameter int unsigned MAX_BURST = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxf_n,
  input  logic       i_txe_n,
  input  logic       i_tx_req,
  input  logic       i_rx_busy,
  input  logic       i_tx_busy,
  input  logic       i_rx_done,
  input  logic       i_tx_done,
  output logic       o_rx_grant,
  output logic       o_tx_grant,
  output logic       o_bus_dir,
  output logic       o_busy,
  output logic [1:0] o_state
);

  localparam int unsigned BW = 8;
  localparam int unsigned TW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RX_OWN = 2'd1,
    ST_TX_OWN = 2'd2,
    ST_TURN   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] turn_q, turn_d;
  logic          last_tx_q, last_tx_d;

  logic          rx_req, tx_rdy;
  logic [BW:0]   burst_inc;
  logic          burst_full;

  // State register; outputs are registered copies decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      burst_q    <= '0;
      turn_q     <= '0;
      last_tx_q  <= 1'b1;
      o_rx_grant <= 1'b0;
      o_tx_grant <= 1'b0;
      o_bus_dir  <= 1'b0;
      o_busy     <= 1'b0;
      o_state    <= 2'd0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      turn_q     <= turn_d;
      last_tx_q  <= last_tx_d;
      o_rx_grant <= (state_d == ST_RX_OWN);
      o_tx_grant <= (state_d == ST_TX_OWN);
      o_bus_dir  <= (state_d == ST_TX_OWN);
      o_busy     <= (state_d != ST_IDLE);
      o_state    <= state_d;
    end
  end

  // Next-state logic. A done pulse is folded into the count before the release test.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    turn_d     = turn_q;
    last_tx_d  = last_tx_q;
    burst_inc  = {1'b0, burst_q};
    burst_full = 1'b0;
    rx_req     = !i_rxf_n;
    tx_rdy     = i_tx_req & !i_txe_n;

    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (rx_req && tx_rdy) begin
          state_d = last_tx_q ? ST_RX_OWN : ST_TX_OWN;
        end else if (rx_req) begin
          state_d = ST_RX_OWN;
        end else if (tx_rdy) begin
          state_d = ST_TX_OWN;
        end
      end

      ST_RX_OWN: begin
        burst_inc  = {1'b0, burst_q} + (BW+1)'(i_rx_done);
        burst_full = (burst_inc >= (BW+1)'(MAX_BURST));
        if (!i_rx_busy && (i_rxf_n || (burst_full && tx_rdy))) begin
          state_d   = ST_TURN;
          last_tx_d = 1'b0;
          burst_d   = '0;
          turn_d    = '0;
        end else if (burst_full) begin
          // Hold at the limit while the other side waits on a strobe; wrap otherwise.
          burst_d = tx_rdy ? BW'(MAX_BURST) : '0;
        end else begin
          burst_d = burst_inc[BW-1:0];
        end
      end

      ST_TX_OWN: begin
        burst_inc  = {1'b0, burst_q} + (BW+1)'(i_tx_done);
        burst_full = (burst_inc >= (BW+1)'(MAX_BURST));
        if (!i_tx_busy && (!tx_rdy || (burst_full && rx_req))) begin
          state_d   = ST_TURN;
          last_tx_d = 1'b1;
          burst_d   = '0;
          turn_d    = '0;
        end else if (burst_full) begin
          burst_d = rx_req ? BW'(MAX_BURST) : '0;
        end else begin
          burst_d = burst_inc[BW-1:0];
        end
      end

      ST_TURN: begin
        if (turn_q == TW'(TURN_CLK - 1)) begin
          state_d = ST_IDLE;
          turn_d  = '0;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft232h_bus_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_ft232h_bus_arbiter;

  localparam int TURN_CLK  = 2;
  localparam int MAX_BURST = 5;
  localparam int STARVE_BOUND = MAX_BURST + TURN_CLK + 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic rxf_n = 1'b1, txe_n = 1'b1, tx_req = 1'b0;
  logic rx_busy = 1'b0, tx_busy = 1'b0, rx_done = 1'b0, tx_done = 1'b0;
  logic o_rx_grant, o_tx_grant, o_bus_dir, o_busy;
  logic [1:0] o_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 idle, 1 rx owns, 2 tx owns, 3 turnaround.
  int m_mode = 0, m_cnt = 0, m_turn = 0;
  bit m_last_tx = 1'b1;

  // Property tracking.
  int cyc = 0, last_rx_cyc = -1, last_tx_cyc = -1;
  int rx_wait = 0, tx_wait = 0;
  logic prev_rx_g = 1'b0, prev_tx_g = 1'b0;

  ft232h_bus_arbiter #(.TURN_CLK(TURN_CLK), .MAX_BURST(MAX_BURST)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rxf_n(rxf_n), .i_txe_n(txe_n), .i_tx_req(tx_req),
    .i_rx_busy(rx_busy), .i_tx_busy(tx_busy), .i_rx_done(rx_done), .i_tx_done(tx_done),
    .o_rx_grant(o_rx_grant), .o_tx_grant(o_tx_grant), .o_bus_dir(o_bus_dir),
    .o_busy(o_busy), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit rxr, txr;
    rxr = !rxf_n;
    txr = tx_req && !txe_n;
    if (i_rst) begin
      m_mode = 0; m_cnt = 0; m_turn = 0; m_last_tx = 1'b1;
      return;
    end
    case (m_mode)
      0: begin
        if (rxr && txr)  m_mode = m_last_tx ? 1 : 2;
        else if (rxr)    m_mode = 1;
        else if (txr)    m_mode = 2;
      end
      1: begin
        if (rx_done) m_cnt++;
        if (!rx_busy && (!rxr || (m_cnt >= MAX_BURST && txr))) begin
          m_mode = 3; m_turn = TURN_CLK; m_cnt = 0; m_last_tx = 1'b0;
        end else if (m_cnt >= MAX_BURST) begin
          m_cnt = txr ? MAX_BURST : 0;
        end
      end
      2: begin
        if (tx_done) m_cnt++;
        if (!tx_busy && (!txr || (m_cnt >= MAX_BURST && rxr))) begin
          m_mode = 3; m_turn = TURN_CLK; m_cnt = 0; m_last_tx = 1'b1;
        end else if (m_cnt >= MAX_BURST) begin
          m_cnt = rxr ? MAX_BURST : 0;
        end
      end
      default: begin
        m_turn--;
        if (m_turn == 0) m_mode = 0;
      end
    endcase
  endtask

  // One clock: model advances on the same edge, outputs checked 1ns later.
  task automatic step();
    bit rxr, txr;
    @(posedge i_clk);
    model_step();
    #1;
    cyc++;
    rxr = !rxf_n;
    txr = tx_req && !txe_n;
    check("outputs", 32'({o_rx_grant, o_tx_grant, o_bus_dir, o_busy, o_state}),
          32'({m_mode == 1, m_mode == 2, m_mode == 2, m_mode != 0, 2'(m_mode)}));
    check("excl", 32'(o_rx_grant & o_tx_grant), 32'd0);
    if (i_rst) begin
      last_rx_cyc = -1; last_tx_cyc = -1; rx_wait = 0; tx_wait = 0;
    end else begin
      if (o_tx_grant && !prev_tx_g && last_rx_cyc >= 0)
        check("turn_rx2tx", 32'((cyc - last_rx_cyc - 1) >= TURN_CLK), 32'd1);
      if (o_rx_grant && !prev_rx_g && last_tx_cyc >= 0)
        check("turn_tx2rx", 32'((cyc - last_tx_cyc - 1) >= TURN_CLK), 32'd1);
      if (prev_tx_g && tx_done && rxr) rx_wait++;
      if (prev_rx_g && rx_done && txr) tx_wait++;
      if (o_rx_grant && !prev_rx_g) check("starve_rx", 32'(rx_wait <= STARVE_BOUND), 32'd1);
      if (o_tx_grant && !prev_tx_g) check("starve_tx", 32'(tx_wait <= STARVE_BOUND), 32'd1);
      if (o_rx_grant || !rxr) rx_wait = 0;
      if (o_tx_grant || !txr) tx_wait = 0;
      if (o_rx_grant) last_rx_cyc = cyc;
      if (o_tx_grant) last_tx_cyc = cyc;
    end
    prev_rx_g = o_rx_grant;
    prev_tx_g = o_tx_grant;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    // 1: reset values, then RX-only request grants after one clock.
    do_reset();
    step();
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_outs", 32'({o_rx_grant, o_tx_grant, o_bus_dir, o_busy}), 32'd0);
    rxf_n = 1'b0;
    step();
    check("t1_rx_grant", 32'(o_rx_grant), 32'd1);
    check("t1_dir", 32'(o_bus_dir), 32'd0);
    rxf_n = 1'b1;
    repeat (3) step();

    // 2: simultaneous requests after reset; RX wins, yields after MAX_BURST bytes.
    do_reset();
    rxf_n = 1'b0; tx_req = 1'b1; txe_n = 1'b0;
    step();
    check("t2_rx_first", 32'({o_rx_grant, o_tx_grant}), 32'b10);
    for (int i = 1; i <= MAX_BURST; i++) begin
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      if (i < MAX_BURST) check("t2_rx_hold", 32'(o_rx_grant), 32'd1);
    end
    check("t2_turn1", 32'({o_rx_grant, o_tx_grant, o_bus_dir, o_state}), 32'b0_0_0_11);
    step();
    check("t2_turn2", 32'({o_rx_grant, o_tx_grant, o_bus_dir, o_state}), 32'b0_0_0_11);
    step();
    check("t2_idle", 32'(o_state), 32'd0);
    step();
    check("t2_tx_own", 32'({o_tx_grant, o_bus_dir, o_state}), 32'b1_1_10);

    // 3: TX request drops mid-strobe; grant held until busy falls.
    rxf_n = 1'b1; tx_req = 1'b0; tx_busy = 1'b1;
    repeat (3) begin
      step();
      check("t3_tx_hold", 32'(o_tx_grant), 32'd1);
    end
    tx_busy = 1'b0;
    step();
    check("t3_turn1", 32'({o_tx_grant, o_state}), 32'b0_11);
    step();
    check("t3_turn2", 32'(o_state), 32'd3);
    step();
    check("t3_idle", 32'(o_state), 32'd0);

    // 4: RX alone for 12 bytes keeps the bus; wrap shows as 3 more bytes to yield.
    txe_n = 1'b1;
    rxf_n = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      check("t4_rx_hold", 32'({o_rx_grant, o_state}), 32'b1_01);
    end
    tx_req = 1'b1; txe_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      check("t4_rx_wrap", 32'(o_state), 32'd1);
    end
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    check("t4_yield", 32'(o_state), 32'd3);
    repeat (3) step();
    check("t4_tx_own", 32'(o_state), 32'd2);

    // 5: reset mid-TX grant drops everything on that edge; RX wins the next tie.
    check("t5_dir_before", 32'(o_bus_dir), 32'd1);
    i_rst = 1'b1;
    step();
    check("t5_rst", 32'({o_tx_grant, o_bus_dir, o_state}), 32'b0_0_00);
    i_rst = 1'b0;
    step();
    check("t5_rx_first", 32'({o_rx_grant, o_tx_grant}), 32'b10);

    // 6: randomized traffic; done pulses only when the engine is not mid-strobe.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) rxf_n  = ~rxf_n;
      if ($urandom_range(7) == 0) txe_n  = ~txe_n;
      if ($urandom_range(7) == 0) tx_req = ~tx_req;
      rx_busy = ($urandom_range(3) == 0);
      tx_busy = ($urandom_range(3) == 0);
      rx_done = !rx_busy && ($urandom_range(2) == 0);
      tx_done = !tx_busy && ($urandom_range(2) == 0);
      i_rst   = ($urandom_range(999) == 0);
      step();
    end
    i_rst = 1'b0; rx_done = 1'b0; tx_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
